exmem_stage: RTL and testbench
==============================

# exmem_stage

Pipeline register between the execute stage (ALU) and the memory stage, with a valid/ready handshake. Captures the ALU result, the 4-bit flags `{N,Z,C,V}` and the control bits of each accepted instruction. Owns the architectural NZCV flag register. Evaluates each instruction's 4-bit condition code against that register, and cancels the side effects (register write, memory write) of instructions whose condition fails.

## Interface
- `N`, 32, datapath width of result and store data
- `clk` input 1 — single clock, all state on rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `flush` input 1 — kill the held entry and drop the incoming beat
- `ex_valid` input 1 — execute stage presents an instruction
- `ex_ready` output 1 — stage can accept this cycle
- `ex_result` input N — ALU result (address or data)
- `ex_flags` input 4 — ALU flags `{N,Z,C,V}`
- `ex_writedata` input N — store data
- `ex_rd` input 4 — destination register
- `ex_cond` input 4 — condition code
- `ex_flagwrite` input 1 — instruction updates NZCV
- `ex_regwrite`, `ex_memwrite`, `ex_memtoreg` input 1 each — control bits
- `mem_valid` output 1 — entry held for the memory stage
- `mem_ready` input 1 — memory stage consumes the entry
- `mem_result`, `mem_writedata` output N — registered copies
- `mem_rd` output 4 — registered destination register
- `mem_regwrite`, `mem_memwrite`, `mem_memtoreg` output 1 each — registered control, gated by condition
- `flags_q` output 4 — architectural NZCV

## Operation
- Single-entry register. `ex_ready = !mem_valid | mem_ready` (combinational).
- Accept occurs when `ex_valid & ex_ready & !flush`.
- On accept:
  - `condpass` is computed from `ex_cond` and the current `flags_q`, using ARM encoding:
    - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
    - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
    - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V
    - C GT !Z&(N==V); D LE Z|(N!=V); E, F always.
  - All data fields are loaded and `mem_valid` is set to 1.
  - `mem_regwrite`, `mem_memwrite` and `mem_memtoreg` are loaded ANDed with `condpass`.
  - The instruction is still forwarded as valid when its condition fails.
  - `flags_q <= ex_flags` only when `ex_flagwrite & condpass`.
- Entry leaves when `mem_valid & mem_ready`. If there is no simultaneous accept, `mem_valid` drops to 0. Accept plus consume in the same cycle replaces the entry with no bubble.
- Stall: while `mem_valid & !mem_ready`, all `mem_*` outputs and `flags_q` hold.
- Flush has priority over everything:
  - next cycle `mem_valid = 0`;
  - the incoming beat is discarded;
  - `flags_q` is not updated by the discarded beat.
  - `ex_ready` is still computed normally during flush.
- When `mem_valid = 0`, the data outputs are don't-care, but the control outputs must be 0.

## Timing
- Reset (asynchronous on `rst_n` low, released synchronously by the design):
  - `mem_valid`, all `mem_*` control bits and `flags_q` = 0;
  - data outputs = 0.
  - Reset mid-stall discards the entry.
- Latency: an instruction accepted at edge k is visible on `mem_*` after edge k. Throughput is 1 per cycle when `mem_ready` is held high.
- Flag hazard: the condition of the instruction accepted at edge k sees flags written by any instruction accepted at edge k-1 or earlier. Back-to-back compare-then-branch needs no stall.
- `ex_ready` depends combinationally on `mem_ready`. No combinational path from `ex_*` to `mem_*`.
- Width: the flag bit order `{N,Z,C,V}` is fixed. Results are passed unmodified; no truncation.

## Test plan
- Reset then stream: hold `mem_ready = 1`; send results 0x1, 0x2, 0x3 on consecutive cycles → `mem_result` shows 1, 2, 3 on consecutive cycles, `mem_valid` continuously 1, `ex_ready` always 1.
- Stall: accept 0xAA, hold `mem_ready = 0` for 3 cycles with `ex_valid = 1` and data 0xBB → `ex_ready = 0`, `mem_result` stays 0xAA. Raising `mem_ready` delivers 0xBB on the next cycle.
- Flags and conditions:
  - CMP with flagwrite and `ex_flags = 0100` (Z set) → `flags_q = 0100`.
  - Next instruction, cond EQ, regwrite=1 → `mem_regwrite = 1`.
  - Next instruction, cond NE, regwrite=1, memwrite=1 → `mem_valid = 1`, `mem_regwrite = 0`, `mem_memwrite = 0`.
- Failed-condition flag write: `flags_q = 0000`; instruction with cond EQ, flagwrite, `ex_flags = 1000` → `flags_q` stays 0000.
- Flush: with entry 0x55 stalled, assert flush together with `ex_valid` and flagwrite `ex_flags = 0010` → next cycle `mem_valid = 0`, `flags_q` unchanged.
- Async reset: assert `rst_n = 0` mid-cycle while `mem_valid = 1` and `flags_q = 1111` → outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/exmem_stage_if.sv
// Handshake and bus bundle between the execute stage, the EX/MEM pipeline
// register and the memory stage. The "slave" modport is the pipeline register
// itself; the "master" modport is the surrounding pipeline (or a testbench)
// that drives the execute beat and the memory-side ready.
interface exmem_stage_if #(
  parameter int N = 32
);
  // Pipeline control
  logic         flush;

  // Execute-stage side
  logic         ex_valid;
  logic         ex_ready;
  logic [N-1:0] ex_result;
  logic [3:0]   ex_flags;
  logic [N-1:0] ex_writedata;
  logic [3:0]   ex_rd;
  logic [3:0]   ex_cond;
  logic         ex_flagwrite;
  logic         ex_regwrite;
  logic         ex_memwrite;
  logic         ex_memtoreg;

  // Memory-stage side
  logic         mem_valid;
  logic         mem_ready;
  logic [N-1:0] mem_result;
  logic [N-1:0] mem_writedata;
  logic [3:0]   mem_rd;
  logic         mem_regwrite;
  logic         mem_memwrite;
  logic         mem_memtoreg;

  // Architectural NZCV flags
  logic [3:0]   flags_q;

  modport master (
    output flush,
    output ex_valid, ex_result, ex_flags, ex_writedata, ex_rd, ex_cond,
    output ex_flagwrite, ex_regwrite, ex_memwrite, ex_memtoreg,
    output mem_ready,
    input  ex_ready,
    input  mem_valid, mem_result, mem_writedata, mem_rd,
    input  mem_regwrite, mem_memwrite, mem_memtoreg,
    input  flags_q
  );

  modport slave (
    input  flush,
    input  ex_valid, ex_result, ex_flags, ex_writedata, ex_rd, ex_cond,
    input  ex_flagwrite, ex_regwrite, ex_memwrite, ex_memtoreg,
    input  mem_ready,
    output ex_ready,
    output mem_valid, mem_result, mem_writedata, mem_rd,
    output mem_regwrite, mem_memwrite, mem_memtoreg,
    output flags_q
  );
endinterface

// File: rtl/exmem_stage.sv
// EX/MEM pipeline register with valid/ready handshake.
// Holds one instruction for the memory stage, owns the architectural NZCV
// flag register, and evaluates each instruction's ARM condition code against
// that register. Instructions whose condition fails still travel down the
// pipe as valid, but with their register-write, memory-write and memtoreg
// side effects cleared, and they never update the flags.
module exmem_stage #(
  parameter int N = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  exmem_stage_if.slave bus
);

  // ARM condition evaluation; nzcv is {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic fn;
    logic fz;
    logic fc;
    logic fv;
    logic pass;
    fn = nzcv[3];
    fz = nzcv[2];
    fc = nzcv[1];
    fv = nzcv[0];
    case (cond)
      4'h0:    pass = fz;
      4'h1:    pass = !fz;
      4'h2:    pass = fc;
      4'h3:    pass = !fc;
      4'h4:    pass = fn;
      4'h5:    pass = !fn;
      4'h6:    pass = fv;
      4'h7:    pass = !fv;
      4'h8:    pass = fc & !fz;
      4'h9:    pass = !fc | fz;
      4'hA:    pass = (fn == fv);
      4'hB:    pass = (fn != fv);
      4'hC:    pass = !fz & (fn == fv);
      4'hD:    pass = fz | (fn != fv);
      default: pass = 1'b1;
    endcase
    return pass;
  endfunction

  // Reset release synchroniser: rst_n asserts asynchronously, but the
  // datapath only leaves reset two clean clock edges after rst_n rises.
  logic [1:0] rst_sync_q;
  logic       run_s;

  // Shift ones into the synchroniser after rst_n deasserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run_s = rst_sync_q[1];

  // Held entry and flag register
  logic         valid_q,     valid_d;
  logic [N-1:0] result_q,    result_d;
  logic [N-1:0] writedata_q, writedata_d;
  logic [3:0]   rd_q,        rd_d;
  logic         regwrite_q,  regwrite_d;
  logic         memwrite_q,  memwrite_d;
  logic         memtoreg_q,  memtoreg_d;
  logic [3:0]   flags_q,     flags_d;

  logic         ex_ready_s;
  logic         accept_s;
  logic         consume_s;
  logic         condpass_s;

  // Handshake decode. ex_ready is held low while the reset release is still
  // in flight so no beat is offered to a register that would ignore it.
  always_comb begin
    ex_ready_s = run_s & (!valid_q | bus.mem_ready);
    accept_s   = bus.ex_valid & ex_ready_s & !bus.flush;
    consume_s  = valid_q & bus.mem_ready;
    condpass_s = cond_pass(bus.ex_cond, flags_q);
  end

  // Next-state for the held entry and the flag register.
  always_comb begin
    valid_d     = valid_q;
    result_d    = result_q;
    writedata_d = writedata_q;
    rd_d        = rd_q;
    regwrite_d  = regwrite_q;
    memwrite_d  = memwrite_q;
    memtoreg_d  = memtoreg_q;
    flags_d     = flags_q;

    if (!run_s) begin
      // Still releasing from reset: keep everything at reset values.
      valid_d     = 1'b0;
      result_d    = '0;
      writedata_d = '0;
      rd_d        = 4'h0;
      regwrite_d  = 1'b0;
      memwrite_d  = 1'b0;
      memtoreg_d  = 1'b0;
      flags_d     = 4'h0;
    end else if (bus.flush) begin
      // Flush kills the held entry and ignores the incoming beat entirely,
      // including any flag write it carries. Control bits are cleared so an
      // empty stage never advertises side effects.
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
    end else if (accept_s) begin
      // New instruction (possibly replacing one consumed this same edge).
      valid_d     = 1'b1;
      result_d    = bus.ex_result;
      writedata_d = bus.ex_writedata;
      rd_d        = bus.ex_rd;
      regwrite_d  = bus.ex_regwrite & condpass_s;
      memwrite_d  = bus.ex_memwrite & condpass_s;
      memtoreg_d  = bus.ex_memtoreg & condpass_s;
      if (bus.ex_flagwrite & condpass_s) begin
        flags_d = bus.ex_flags;
      end else begin
        flags_d = flags_q;
      end
    end else if (consume_s) begin
      // Entry leaves with nothing to replace it.
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
    end else begin
      // Idle or stalled: hold.
      valid_d = valid_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      result_q    <= '0;
      writedata_q <= '0;
      rd_q        <= 4'h0;
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      flags_q     <= 4'h0;
    end else begin
      valid_q     <= valid_d;
      result_q    <= result_d;
      writedata_q <= writedata_d;
      rd_q        <= rd_d;
      regwrite_q  <= regwrite_d;
      memwrite_q  <= memwrite_d;
      memtoreg_q  <= memtoreg_d;
      flags_q     <= flags_d;
    end
  end

  // Outputs come straight from flops; only ex_ready is combinational.
  assign bus.ex_ready      = ex_ready_s;
  assign bus.mem_valid     = valid_q;
  assign bus.mem_result    = result_q;
  assign bus.mem_writedata = writedata_q;
  assign bus.mem_rd        = rd_q;
  assign bus.mem_regwrite  = regwrite_q;
  assign bus.mem_memwrite  = memwrite_q;
  assign bus.mem_memtoreg  = memtoreg_q;
  assign bus.flags_q       = flags_q;

endmodule

// File: tb/tb_exmem_stage.sv
// Self-checking bench for exmem_stage: directed scenarios followed by random
// traffic. A driver issues beats and pushes the expected entry into a
// scoreboard queue; a monitor on the falling edge compares the DUT outputs
// against the queue head and the reference flag register.
module tb_exmem_stage;

  logic clk;
  logic rst_n;

  exmem_stage_if #(.N(32)) bus ();

  exmem_stage #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] wd;
    logic [3:0]  rd;
    logic        rw;
    logic        mw;
    logic        mtr;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] model_flags;
  bit         chk_en;
  int         n_cmp;
  int         n_bad;

  // Reference condition check written the way the architecture manual
  // describes it: a base predicate per pair, inverted by cond[0] except 1111.
  function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
    logic b;
    case (cond[3:1])
      3'd0:    b = f[2];
      3'd1:    b = f[1];
      3'd2:    b = f[3];
      3'd3:    b = f[0];
      3'd4:    b = f[1] && !f[2];
      3'd5:    b = (f[3] == f[0]);
      3'd6:    b = !f[2] && (f[3] == f[0]);
      default: b = 1'b1;
    endcase
    if (cond[0] && cond[3:1] != 3'd7) return !b;
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs against the scoreboard, then retire the head
  // if this coming edge consumes or flushes it.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ex_ready", {31'd0, bus.ex_ready}, {31'd0, (sb_q.size() == 0) || bus.mem_ready});
      chk("mem_valid", {31'd0, bus.mem_valid}, {31'd0, sb_q.size() != 0});
      chk("flags_q", {28'd0, bus.flags_q}, {28'd0, model_flags});
      if (sb_q.size() != 0) begin
        chk("mem_result", bus.mem_result, sb_q[0].res);
        chk("mem_writedata", bus.mem_writedata, sb_q[0].wd);
        chk("mem_rd", {28'd0, bus.mem_rd}, {28'd0, sb_q[0].rd});
        chk("mem_ctrl", {29'd0, bus.mem_regwrite, bus.mem_memwrite, bus.mem_memtoreg},
            {29'd0, sb_q[0].rw, sb_q[0].mw, sb_q[0].mtr});
      end else begin
        chk("idle_ctrl", {29'd0, bus.mem_regwrite, bus.mem_memwrite, bus.mem_memtoreg}, 32'd0);
      end
      if (bus.flush) begin
        sb_q.delete();
      end else if (sb_q.size() != 0 && bus.mem_ready) begin
        void'(sb_q.pop_front());
      end
    end
  end

  // One cycle of stimulus, called just after a rising edge. Predicts whether
  // the beat is accepted and what the memory stage should later see.
  task automatic step(input logic v, input logic [31:0] res, input logic [31:0] wd,
                      input logic [3:0] rd, input logic [3:0] fl, input logic [3:0] cond,
                      input logic fw, input logic rw, input logic mw, input logic mtr,
                      input logic mr, input logic fsh);
    logic acc;
    logic cp;
    exp_t e;
    bus.ex_valid     = v;
    bus.ex_result    = res;
    bus.ex_writedata = wd;
    bus.ex_rd        = rd;
    bus.ex_flags     = fl;
    bus.ex_cond      = cond;
    bus.ex_flagwrite = fw;
    bus.ex_regwrite  = rw;
    bus.ex_memwrite  = mw;
    bus.ex_memtoreg  = mtr;
    bus.mem_ready    = mr;
    bus.flush        = fsh;
    acc   = v && !fsh && ((sb_q.size() == 0) || mr);
    cp    = ref_cond(cond, model_flags);
    e.res = res;
    e.wd  = wd;
    e.rd  = rd;
    e.rw  = rw && cp;
    e.mw  = mw && cp;
    e.mtr = mtr && cp;
    @(posedge clk);
    #1;
    if (acc) begin
      sb_q.push_back(e);
      if (fw && cp) model_flags = fl;
    end
  endtask

  task automatic idle(input logic mr);
    step(1'b0, 32'd0, 32'd0, 4'h0, 4'h0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, mr, 1'b0);
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    chk_en       = 1'b0;
    model_flags  = 4'h0;
    rst_n        = 1'b0;
    bus.flush        = 1'b0;
    bus.ex_valid     = 1'b0;
    bus.ex_result    = 32'd0;
    bus.ex_writedata = 32'd0;
    bus.ex_rd        = 4'h0;
    bus.ex_flags     = 4'h0;
    bus.ex_cond      = 4'hE;
    bus.ex_flagwrite = 1'b0;
    bus.ex_regwrite  = 1'b0;
    bus.ex_memwrite  = 1'b0;
    bus.ex_memtoreg  = 1'b0;
    bus.mem_ready    = 1'b0;

    // Reset state
    #12;
    chk("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("rst_flags", {28'd0, bus.flags_q}, 32'd0);
    chk("rst_result", bus.mem_result, 32'd0);
    chk("rst_writedata", bus.mem_writedata, 32'd0);
    chk("rst_ctrl", {29'd0, bus.mem_regwrite, bus.mem_memwrite, bus.mem_memtoreg}, 32'd0);
    #10;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Stream 1, 2, 3 with mem_ready held high
    step(1'b1, 32'h1, 32'h10, 4'h1, 4'h0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h2, 32'h20, 4'h2, 4'h0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h3, 32'h30, 4'h3, 4'h0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Stall: 0xAA held while 0xBB waits
    step(1'b1, 32'hAA, 32'h0, 4'h4, 4'h0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'hBB, 32'h0, 4'h5, 4'h0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hBB, 32'h0, 4'h5, 4'h0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // CMP sets Z, then EQ passes and NE fails back-to-back
    step(1'b1, 32'h0, 32'h0, 4'h0, 4'b0100, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h11, 32'h0, 4'h6, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h22, 32'h33, 4'h7, 4'h0, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b1);

    // Clear flags, then an EQ flag write must be cancelled
    step(1'b1, 32'h0, 32'h0, 4'h0, 4'b0000, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h44, 32'h0, 4'h8, 4'b1000, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Flush a stalled 0x55 together with a flag-writing beat
    step(1'b1, 32'h55, 32'h0, 4'h9, 4'h0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    step(1'b1, 32'h66, 32'h0, 4'hA, 4'b0010, 4'hE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b1);

    // Asynchronous reset mid-stall with flags = 1111
    step(1'b1, 32'h77, 32'h0, 4'hB, 4'b1111, 4'hE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    chk_en = 1'b0;
    #1;
    chk("pre_rst_valid", {31'd0, bus.mem_valid}, 32'd1);
    chk("pre_rst_flags", {28'd0, bus.flags_q}, 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("async_rst_flags", {28'd0, bus.flags_q}, 32'd0);
    chk("async_rst_result", bus.mem_result, 32'd0);
    chk("async_rst_ctrl", {29'd0, bus.mem_regwrite, bus.mem_memwrite, bus.mem_memtoreg}, 32'd0);
    sb_q.delete();
    model_flags   = 4'h0;
    bus.ex_valid  = 1'b0;
    bus.mem_ready = 1'b1;
    #20;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom, 4'($urandom), 4'($urandom),
           4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
